// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: control FSM for the LED-matrix puzzle game.
// It sequences start, level play, the pause after a completed level, the
// level advance, and the win. It drives the level counter and the matrix
// clear signals of fluxo_dados.
// Optional feature: define TIMEOUT_EN to add a per-level time limit. When the
// limit runs out the game is lost (state PERDEU). Without it, perdeu stays 0.
module unidade_controle_jogo #(
  parameter int TRANSICAO_CICLOS = 50_000_000,
  parameter int TIMEOUT_CICLOS   = 500_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       reiniciar,
  input  logic       nivel_concluido,
  input  logic       nivelIgualUltimoNivel,
  output logic       contaN,
  output logic       zeraN,
  output logic       zeraM,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    PREPARA  = 4'd1,
    JOGANDO  = 4'd2,
    NIVEL_OK = 4'd3,
    PROXIMO  = 4'd4,
    CARREGA  = 4'd5,
    VENCEU   = 4'd6,
    PERDEU   = 4'd7
  } estado_t;

  localparam int TW = (TRANSICAO_CICLOS > 1) ? $clog2(TRANSICAO_CICLOS) : 1;
  localparam logic [TW-1:0] TRANS_FIM = TW'(TRANSICAO_CICLOS - 1);

  estado_t       estado, prox;
  logic [TW-1:0] cnt_trans;
  logic          fim_trans;
  logic          timeout;

  assign fim_trans = (cnt_trans == TRANS_FIM);

`ifdef TIMEOUT_EN
  localparam int OW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [OW-1:0] TEMPO_FIM = OW'(TIMEOUT_CICLOS - 1);
  logic [OW-1:0] cnt_tempo;

  assign timeout = (cnt_tempo == TEMPO_FIM);

  // Time spent in the current level. The counter restarts on every entry to JOGANDO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                cnt_tempo <= '0;
    else if (estado == JOGANDO && prox == JOGANDO) cnt_tempo <= cnt_tempo + OW'(1);
    else                                       cnt_tempo <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  // Pause counter. It only runs while the FSM stays in NIVEL_OK, so every entry starts from 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                      cnt_trans <= '0;
    else if (estado == NIVEL_OK && prox == NIVEL_OK) cnt_trans <= cnt_trans + TW'(1);
    else                                             cnt_trans <= '0;
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= prox;
  end

  // Next state and Moore outputs. Outputs depend on the state only.
  always_comb begin
    prox   = estado;
    contaN = 1'b0;
    zeraN  = 1'b0;
    zeraM  = 1'b0;
    pronto = 1'b0;
    ganhou = 1'b0;
    perdeu = 1'b0;
    case (estado)
      INICIAL:  if (iniciar) prox = PREPARA;
      PREPARA: begin
        zeraN = 1'b1;
        zeraM = 1'b1;
        prox  = JOGANDO;
      end
      JOGANDO: begin
        if (reiniciar)                                     prox = PREPARA;
        else if (nivel_concluido && nivelIgualUltimoNivel) prox = VENCEU;
        else if (nivel_concluido)                          prox = NIVEL_OK;
        else if (timeout)                                  prox = PERDEU;
      end
      NIVEL_OK: begin
        if (reiniciar)      prox = PREPARA;
        else if (fim_trans) prox = PROXIMO;
      end
      PROXIMO: begin
        contaN = 1'b1;
        zeraM  = 1'b1;
        prox   = CARREGA;
      end
      // Guard cycle. The matrix reloads here, so a stale nivel_concluido is ignored.
      CARREGA:  prox = JOGANDO;
      VENCEU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
        if (iniciar || reiniciar) prox = PREPARA;
      end
      PERDEU: begin
        pronto = 1'b1;
        perdeu = 1'b1;
        if (iniciar || reiniciar) prox = PREPARA;
      end
      default:  prox = INICIAL;
    endcase
  end

  assign db_estado = estado;

endmodule
